// File: rtl/viking_mem_port.sv
// Video fetch port: one 4-beat SDRAM burst per bus slot, assembled to 64 bits.
// Optional overrun counter enabled by defining VIKING_OVR_COUNT_EN.
module viking_mem_port (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        bus_sync,
  input  logic        vid_read,
  input  logic [22:0] vid_addr,
  output logic [63:0] vid_data,
  output logic        ram_req,
  output logic [22:0] ram_addr,
  input  logic        ram_ack,
  input  logic        ram_dvalid,
  input  logic [15:0] ram_dq,
  output logic        overrun,
  output logic [7:0]  ovr_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]  state;
  logic [1:0]  beat;
  logic [47:0] asm_q;
  logic        sync_q;
  logic        slot;
  logic        last_beat;
  logic        ovr_evt;

  // Slot edge, final-beat and overrun-event decode
  always_comb begin
    slot      = bus_sync & ~sync_q;
    last_beat = 1'b0;
    ovr_evt   = 1'b0;
    if (state == DATA)
      last_beat = ram_dvalid & (beat == 2'd3);
    if (slot) begin
      unique case (1'b1)
        state == REQ:  ovr_evt = 1'b1;
        state == DATA: ovr_evt = ~last_beat;
        default:       ovr_evt = 1'b0;
      endcase
    end
  end

  // Previous bus_sync level for edge detection
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)
      sync_q <= 1'b0;
    else
      sync_q <= bus_sync;
  end

  // Burst FSM: request, handshake, beat assembly and delivery
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ram_req  <= 1'b0;
      ram_addr <= 23'd0;
      beat     <= 2'd0;
      asm_q    <= 48'd0;
      vid_data <= 64'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (slot && vid_read) begin
            ram_addr <= vid_addr;
            ram_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            beat    <= 2'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (ram_dvalid) begin
            beat <= beat + 2'd1;
            unique case (beat)
              2'd0: asm_q[15:0]  <= ram_dq;
              2'd1: asm_q[31:16] <= ram_dq;
              2'd2: asm_q[47:32] <= ram_dq;
              default: begin
                vid_data <= {ram_dq, asm_q};
                state    <= IDLE;
              end
            endcase
          end
        end
        default: begin
          state   <= IDLE;
          ram_req <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)
      overrun <= 1'b0;
    else if (ovr_evt)
      overrun <= 1'b1;
  end

`ifdef VIKING_OVR_COUNT_EN
  logic [7:0] cnt_q;

  // Saturating count of overrun events
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= 8'd0;
    else if (ovr_evt && cnt_q != 8'hff)
      cnt_q <= cnt_q + 8'd1;
  end

  assign ovr_cnt = cnt_q;
`else
  assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_viking_mem_port.sv
// Directed bench for viking_mem_port: vector table plus reset and
// saturation sequences.
module tb_viking_mem_port;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_sync = 1'b0;
  logic        vid_read = 1'b0;
  logic [22:0] vid_addr = '0;
  logic [63:0] vid_data;
  logic        ram_req;
  logic [22:0] ram_addr;
  logic        ram_ack = 1'b0;
  logic        ram_dvalid = 1'b0;
  logic [15:0] ram_dq = '0;
  logic        overrun;
  logic [7:0]  ovr_cnt;

  int checks = 0;
  int fails  = 0;

`ifdef VIKING_OVR_COUNT_EN
  localparam logic [7:0] OC1   = 8'd1;
  localparam logic [7:0] OCSAT = 8'd255;
`else
  localparam logic [7:0] OC1   = 8'd0;
  localparam logic [7:0] OCSAT = 8'd0;
`endif

  viking_mem_port dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .bus_sync   (bus_sync),
    .vid_read   (vid_read),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .ram_req    (ram_req),
    .ram_addr   (ram_addr),
    .ram_ack    (ram_ack),
    .ram_dvalid (ram_dvalid),
    .ram_dq     (ram_dq),
    .overrun    (overrun),
    .ovr_cnt    (ovr_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        s;
    logic        rd;
    logic [22:0] a;
    logic        ack;
    logic        dv;
    logic [15:0] dq;
    logic        req;
    logic [22:0] raddr;
    logic [63:0] data;
    logic        ovr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic rd,
                      input logic [22:0] a, input logic ack,
                      input logic dv, input logic [15:0] dq);
    bus_sync   = s;
    vid_read   = rd;
    vid_addr   = a;
    ram_ack    = ack;
    ram_dvalid = dv;
    ram_dq     = dq;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_all(input string p, input logic req,
                         input logic [22:0] ra, input logic [63:0] d,
                         input logic ov, input logic [7:0] c);
    chk({p, "_req"}, {63'd0, ram_req}, {63'd0, req});
    chk({p, "_addr"}, {41'd0, ram_addr}, {41'd0, ra});
    chk({p, "_data"}, vid_data, d);
    chk({p, "_ovr"}, {63'd0, overrun}, {63'd0, ov});
    chk({p, "_cnt"}, {56'd0, ovr_cnt}, {56'd0, c});
  endtask

  localparam logic [22:0] A0 = 23'h600000;
  localparam logic [22:0] A1 = 23'h123456;
  localparam logic [22:0] A2 = 23'h000010;
  localparam logic [63:0] D0 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] D1 = 64'hdddd_cccc_bbbb_aaaa;
  localparam logic [63:0] D2 = 64'h0004_0003_0002_0001;

  initial begin
    // s rd addr ack dv dq | req raddr data ovr cnt
    vecs.push_back('{0,1,A0,0,0,16'h0,   0,0, 0, 0,0});
    vecs.push_back('{1,1,A0,0,0,16'h0,   1,A0,0, 0,0});
    vecs.push_back('{1,1,A0,0,0,16'h0,   1,A0,0, 0,0});
    vecs.push_back('{0,1,A0,1,0,16'h0,   0,A0,0, 0,0});
    vecs.push_back('{0,0,0, 0,1,16'h1111,0,A0,0, 0,0});
    vecs.push_back('{0,0,0, 0,1,16'h2222,0,A0,0, 0,0});
    vecs.push_back('{0,0,0, 0,1,16'h3333,0,A0,0, 0,0});
    vecs.push_back('{0,0,0, 0,1,16'h4444,0,A0,D0,0,0});
    vecs.push_back('{0,0,0, 0,1,16'hffff,0,A0,D0,0,0});
    vecs.push_back('{1,0,A1,0,0,16'h0,   0,A0,D0,0,0});
    vecs.push_back('{0,0,A1,0,0,16'h0,   0,A0,D0,0,0});
    vecs.push_back('{1,1,A1,0,0,16'h0,   1,A1,D0,0,0});
    vecs.push_back('{0,1,A2,0,0,16'h0,   1,A1,D0,0,0});
    vecs.push_back('{1,1,A2,0,0,16'h0,   1,A1,D0,1,OC1});
    vecs.push_back('{0,0,0, 1,0,16'h0,   0,A1,D0,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'haaaa,0,A1,D0,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'hbbbb,0,A1,D0,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'hcccc,0,A1,D0,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'hdddd,0,A1,D1,1,OC1});
    vecs.push_back('{0,0,0, 0,0,16'h0,   0,A1,D1,1,OC1});
    vecs.push_back('{1,1,A2,0,0,16'h0,   1,A2,D1,1,OC1});
    vecs.push_back('{0,0,0, 1,0,16'h0,   0,A2,D1,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'h0001,0,A2,D1,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'h0002,0,A2,D1,1,OC1});
    vecs.push_back('{0,0,0, 0,1,16'h0003,0,A2,D1,1,OC1});
    vecs.push_back('{1,1,A1,0,1,16'h0004,0,A2,D2,1,OC1});
    vecs.push_back('{1,1,A1,0,0,16'h0,   0,A2,D2,1,OC1});

    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge pclk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].rd, vecs[i].a,
           vecs[i].ack, vecs[i].dv, vecs[i].dq);
      chk_all($sformatf("v%0d", i), vecs[i].req, vecs[i].raddr,
              vecs[i].data, vecs[i].ovr, vecs[i].cnt);
    end

    // Reset in the middle of a burst
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 23'h0abcde, 0, 0, 0);
    chk("mid_req", {63'd0, ram_req}, 64'd1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 16'h5555);
    step(0, 0, 0, 0, 1, 16'h6666);
    ram_dvalid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    step(0, 1, 0, 0, 1, 16'h7777);
    step(0, 1, 0, 0, 1, 16'h8888);
    step(0, 1, 0, 0, 1, 16'h9999);
    step(0, 1, 0, 0, 1, 16'haaaa);
    chk_all("post_rst", 0, 0, 0, 0, 0);

    // 300 forced overruns: second slot edge arrives before ack
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 23'h000100, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 16'h0101);
      step(0, 0, 0, 0, 1, 16'h0202);
      step(0, 0, 0, 0, 1, 16'h0303);
      step(0, 0, 0, 0, 1, 16'h0404);
    end
    chk_all("sat", 0, 23'h000100, 64'h0404_0303_0202_0101, 1, OCSAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/viking_mem_port.md
VIKING_MEM_PORT -- requirements
Module: viking_mem_port

Interface
REQ-001 Parameters: none.
REQ-002 pclk  in  1  pixel clock; the only clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 bus_sync  in  1  2 MHz bus phase marker; its rising edge opens a fetch slot.
REQ-005 vid_read  in  1  video read request, level, from display stage.
REQ-006 vid_addr  in  23  video word address (16-bit word units).
REQ-007 vid_data  out  64  fetched 64-bit group: beat k in bits [16k+15:16k].
REQ-008 ram_req  out  1  burst request to SDRAM controller.
REQ-009 ram_addr  out  23  burst start word address.
REQ-010 ram_ack  in  1  one-cycle accept of ram_req.
REQ-011 ram_dvalid  in  1  one beat of read data valid this cycle.
REQ-012 ram_dq  in  16  read data beat.
REQ-013 overrun  out  1  sticky: a burst failed to complete within its slot.
REQ-014 ovr_cnt  out  8  overrun event count (see Configuration).

Function
REQ-015 Slot edge = bus_sync high this cycle, low previous cycle (one-register edge detect).
REQ-016 States: IDLE, REQ, DATA; one burst in flight max.
REQ-017 IDLE: on slot edge with vid_read=1, latch vid_addr into ram_addr, ram_req<=1, go REQ; vid_read=0 -> stay IDLE.
REQ-018 REQ: ram_req held high until ram_ack sampled high; then ram_req<=0, beat counter<=0, go DATA.
REQ-019 DATA: each ram_dvalid writes ram_dq into assembly slot [beat]; beat counter 2 bits, increments per beat.
REQ-020 4th beat: assembled 64 bits copied to vid_data in same cycle as that beat's register update; go IDLE.
REQ-021 vid_data changes only at 4th-beat completion; otherwise holds.
REQ-022 ram_dvalid outside DATA is ignored.
REQ-023 Slot edge while in REQ or DATA = overrun: overrun<=1, vid_data unchanged, new request not issued; current burst finishes and its data is delivered normally.
REQ-024 Slot edge coinciding with 4th beat: data delivered, no overrun, new request evaluated on the next slot edge only.
REQ-025 Latency contract: request sampled at slot edge N; vid_data valid no later than slot edge N+1 when controller honours slot timing.
REQ-026 overrun clears only on reset.

Reset
REQ-027 reset_n low, asynchronously: state IDLE, ram_req=0, ram_addr=0, vid_data=0, overrun=0, ovr_cnt=0, beat counter=0, edge register=0.
REQ-028 Reset mid-burst: burst abandoned; beats arriving after release ignored (state IDLE).

Configuration
REQ-029 Macro VIKING_OVR_COUNT_EN defined: ovr_cnt increments by 1 per overrun event, saturates at 255.
REQ-030 Macro undefined: ovr_cnt tied to 0; overrun flag behaviour unchanged.

Verification
REQ-031 vid_addr=23'h600000, vid_read=1, slot edge; ack 2 cycles later; beats 1111,2222,3333,4444 -> ram_addr=600000, vid_data=64'h4444_3333_2222_1111, overrun=0.
REQ-032 ram_ack withheld past next slot edge -> overrun=1, ovr_cnt=1 (macro on) / 0 (macro off); late burst still delivers its data.
REQ-033 vid_read=0 at slot edge -> ram_req stays 0, vid_data unchanged.
REQ-034 Stray ram_dvalid in IDLE with ram_dq=FFFF -> vid_data unchanged.
REQ-035 reset_n pulsed low after 2 beats -> all outputs 0 immediately; further beats ignored.
REQ-036 300 forced overruns, macro on -> ovr_cnt=255.
